// File: rtl/mem_stage_lsu_if.sv
// rtl/mem_stage_lsu_if.sv - req/ack data bus between the MEM-stage LSU and memory
//
// Purpose: bundles the data-bus handshake so the LSU and memory see one port.
// Signals:
//   bus_req   master->slave  access request, held until bus_ack
//   bus_we    master->slave  1 = write
//   bus_addr  master->slave  word-aligned byte address
//   bus_wrstb master->slave  byte-lane write strobes (0 on reads)
//   bus_wdata master->slave  store data placed in its byte lanes
//   bus_ack   slave->master  access completes this cycle
//   bus_rdata slave->master  read data, valid with bus_ack
interface mem_stage_lsu_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    localparam int NB = DATA_W / 8;

    logic              bus_req;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [NB-1:0]     bus_wrstb;
    logic [DATA_W-1:0] bus_wdata;
    logic              bus_ack;
    logic [DATA_W-1:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wrstb, bus_wdata,
        input  bus_ack, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wrstb, bus_wdata,
        output bus_ack, bus_rdata
    );
endinterface

// File: rtl/mem_stage_lsu.sv
// rtl/mem_stage_lsu.sv - MEM-stage load/store unit with req/ack bus, alignment and fault reporting
//
// Purpose: accepts one MEM-stage request per cycle. NONE requests pass through
// to the MEM/WB outputs; aligned LOAD/STORE requests run one req/ack bus access
// while stalling upstream; misaligned requests and bus timeouts raise a fault.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   req_*_i               MEM-stage request (valid, op, size, sign, addr, data, rd)
//   stall_o               hold upstream stages (combinational)
//   bus                   data bus, master side
//   wb_valid_o            registered one-cycle result pulse
//   wb_rd_addr_o          destination register (0 for stores and faults)
//   wb_rd_data_o          result data
//   fault_o               registered one-cycle fault pulse
//   fault_cause_o         1 = misaligned, 2 = timeout; held until the next fault
module mem_stage_lsu #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_i,
    input  logic [1:0]        req_mem_op_i,
    input  logic [1:0]        req_size_i,
    input  logic              req_signed_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [DATA_W-1:0] req_wdata_i,
    input  logic [4:0]        req_rd_addr_i,
    input  logic [DATA_W-1:0] req_rd_data_i,
    output logic              stall_o,
    mem_stage_lsu_if.master   bus,
    output logic              wb_valid_o,
    output logic [4:0]        wb_rd_addr_o,
    output logic [DATA_W-1:0] wb_rd_data_o,
    output logic              fault_o,
    output logic [1:0]        fault_cause_o
);
    localparam int NB     = DATA_W / 8;
    localparam int LG_NB  = $clog2(NB);
    localparam int LANE_W = (LG_NB > 0) ? LG_NB : 1;
    localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [1:0] OP_LOAD  = 2'd1;
    localparam logic [1:0] OP_STORE = 2'd2;
    localparam logic [1:0] CAUSE_MISALIGN = 2'd1;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'd2;

    typedef enum logic {S_IDLE, S_BUS} state_e;

    state_e state_q, state_d;

    // Access context captured at acceptance, used while the bus is busy
    logic              is_load_q,   is_load_d;
    logic [1:0]        size_q,      size_d;
    logic              signed_q,    signed_d;
    logic [LANE_W-1:0] lane_q,      lane_d;
    logic [4:0]        rd_addr_q,   rd_addr_d;
    logic [CNT_W-1:0]  cnt_q,       cnt_d;

    // Registered bus outputs
    logic              bus_we_q,    bus_we_d;
    logic [ADDR_W-1:0] bus_addr_q,  bus_addr_d;
    logic [NB-1:0]     bus_wrstb_q, bus_wrstb_d;
    logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;

    // Registered MEM/WB outputs
    logic              wb_valid_q,    wb_valid_d;
    logic [4:0]        wb_rd_addr_q,  wb_rd_addr_d;
    logic [DATA_W-1:0] wb_rd_data_q,  wb_rd_data_d;
    logic              fault_q,       fault_d;
    logic [1:0]        fault_cause_q, fault_cause_d;

    // Request decode
    logic              accept;
    logic              is_mem;
    logic              aligned;
    logic              go_bus;
    logic              misalign;
    logic              pass_through;
    logic [2:0]        low_mask;
    logic [LANE_W-1:0] req_lane;
    logic [NB-1:0]     size_mask;
    int                size_bytes;

    // Bus completion decode
    logic              in_bus;
    logic              done_ok;
    logic              tmo_hit;

    // Load data alignment
    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] load_data;
    logic              sign_bit;
    int                nbits;

    assign accept       = (state_q == S_IDLE) && req_valid_i;
    assign is_mem       = (req_mem_op_i == OP_LOAD) || (req_mem_op_i == OP_STORE);
    assign go_bus       = accept && is_mem && aligned;
    assign misalign     = accept && is_mem && !aligned;
    assign pass_through = accept && !is_mem;

    assign in_bus  = (state_q == S_BUS);
    assign done_ok = in_bus && bus.bus_ack;
    // An ack in the timeout cycle counts as a normal completion
    assign tmo_hit = (TIMEOUT > 0) && in_bus && !bus.bus_ack && (cnt_q == CNT_W'(TIMEOUT));

    assign req_lane = (NB > 1) ? req_addr_i[LANE_W-1:0] : '0;

    // Aligned when the low size bits of the address are zero and the
    // access is no wider than the bus.
    always_comb begin
        low_mask = 3'b000;
        case (req_size_i)
            2'd0:    low_mask = 3'b000;
            2'd1:    low_mask = 3'b001;
            2'd2:    low_mask = 3'b011;
            default: low_mask = 3'b111;
        endcase
        aligned = ((req_addr_i[2:0] & low_mask) == 3'b000) && (int'(req_size_i) <= LG_NB);
    end

    always_comb begin
        size_bytes = 1 << req_size_i;
        size_mask  = '0;
        for (int i = 0; i < NB; i++) begin
            size_mask[i] = (i < size_bytes);
        end
    end

    // Load data: move the addressed lane to bit 0, keep size bytes, extend
    always_comb begin
        shifted  = bus.bus_rdata >> {lane_q, 3'b000};
        nbits    = 8 << size_q;
        sign_bit = 1'b0;
        for (int i = 0; i < DATA_W; i++) begin
            if (i == nbits - 1) sign_bit = shifted[i];
        end
        load_data = '0;
        for (int i = 0; i < DATA_W; i++) begin
            if (i < nbits) load_data[i] = shifted[i];
            else           load_data[i] = signed_q & sign_bit;
        end
    end

    // FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (go_bus) state_d = S_BUS;
            S_BUS:   if (bus.bus_ack || tmo_hit) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        bus.bus_req = in_bus;
        stall_o     = go_bus || (in_bus && !bus.bus_ack && !tmo_hit);
    end

    // Datapath next-state
    always_comb begin
        is_load_d     = is_load_q;
        size_d        = size_q;
        signed_d      = signed_q;
        lane_d        = lane_q;
        rd_addr_d     = rd_addr_q;
        cnt_d         = cnt_q;
        bus_we_d      = bus_we_q;
        bus_addr_d    = bus_addr_q;
        bus_wrstb_d   = bus_wrstb_q;
        bus_wdata_d   = bus_wdata_q;
        wb_valid_d    = 1'b0;
        wb_rd_addr_d  = wb_rd_addr_q;
        wb_rd_data_d  = wb_rd_data_q;
        fault_d       = 1'b0;
        fault_cause_d = fault_cause_q;

        if (go_bus) begin
            is_load_d   = (req_mem_op_i == OP_LOAD);
            size_d      = req_size_i;
            signed_d    = req_signed_i;
            lane_d      = req_lane;
            rd_addr_d   = req_rd_addr_i;
            cnt_d       = '0;
            bus_we_d    = (req_mem_op_i == OP_STORE);
            bus_addr_d  = req_addr_i & ~ADDR_W'(NB - 1);
            bus_wrstb_d = (req_mem_op_i == OP_STORE) ? (size_mask << req_lane) : '0;
            bus_wdata_d = req_wdata_i << {req_lane, 3'b000};
        end

        if (pass_through) begin
            wb_valid_d   = 1'b1;
            wb_rd_addr_d = req_rd_addr_i;
            wb_rd_data_d = req_rd_data_i;
        end

        if (misalign) begin
            fault_d       = 1'b1;
            fault_cause_d = CAUSE_MISALIGN;
            wb_rd_addr_d  = '0;
            wb_rd_data_d  = '0;
        end

        if (done_ok) begin
            wb_valid_d   = 1'b1;
            wb_rd_addr_d = is_load_q ? rd_addr_q : 5'd0;
            wb_rd_data_d = is_load_q ? load_data : '0;
        end

        if (tmo_hit) begin
            fault_d       = 1'b1;
            fault_cause_d = CAUSE_TIMEOUT;
            wb_rd_addr_d  = '0;
            wb_rd_data_d  = '0;
        end

        // Saturating wait counter; it only matters while an access is open
        if (in_bus && !bus.bus_ack && (TIMEOUT > 0) && (cnt_q != CNT_W'(TIMEOUT))) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            is_load_q     <= 1'b0;
            size_q        <= '0;
            signed_q      <= 1'b0;
            lane_q        <= '0;
            rd_addr_q     <= '0;
            cnt_q         <= '0;
            bus_we_q      <= 1'b0;
            bus_addr_q    <= '0;
            bus_wrstb_q   <= '0;
            bus_wdata_q   <= '0;
            wb_valid_q    <= 1'b0;
            wb_rd_addr_q  <= '0;
            wb_rd_data_q  <= '0;
            fault_q       <= 1'b0;
            fault_cause_q <= '0;
        end else begin
            is_load_q     <= is_load_d;
            size_q        <= size_d;
            signed_q      <= signed_d;
            lane_q        <= lane_d;
            rd_addr_q     <= rd_addr_d;
            cnt_q         <= cnt_d;
            bus_we_q      <= bus_we_d;
            bus_addr_q    <= bus_addr_d;
            bus_wrstb_q   <= bus_wrstb_d;
            bus_wdata_q   <= bus_wdata_d;
            wb_valid_q    <= wb_valid_d;
            wb_rd_addr_q  <= wb_rd_addr_d;
            wb_rd_data_q  <= wb_rd_data_d;
            fault_q       <= fault_d;
            fault_cause_q <= fault_cause_d;
        end
    end

    assign bus.bus_we    = bus_we_q;
    assign bus.bus_addr  = bus_addr_q;
    assign bus.bus_wrstb = bus_wrstb_q;
    assign bus.bus_wdata = bus_wdata_q;

    assign wb_valid_o    = wb_valid_q;
    assign wb_rd_addr_o  = wb_rd_addr_q;
    assign wb_rd_data_o  = wb_rd_data_q;
    assign fault_o       = fault_q;
    assign fault_cause_o = fault_cause_q;
endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb/tb_mem_stage_lsu.sv - directed self-checking bench for mem_stage_lsu
module tb_mem_stage_lsu;
    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 32;
    localparam int TIMEOUT = 4;

    localparam logic [1:0] OP_NONE  = 2'd0;
    localparam logic [1:0] OP_LOAD  = 2'd1;
    localparam logic [1:0] OP_STORE = 2'd2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic [1:0]  req_mem_op;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd_addr;
    logic [31:0] req_rd_data;
    logic        stall;
    logic        wb_valid;
    logic [4:0]  wb_rd_addr;
    logic [31:0] wb_rd_data;
    logic        fault;
    logic [1:0]  fault_cause;

    int n_checks = 0;
    int n_fail   = 0;

    mem_stage_lsu_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus_if ();

    mem_stage_lsu #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid_i   (req_valid),
        .req_mem_op_i  (req_mem_op),
        .req_size_i    (req_size),
        .req_signed_i  (req_signed),
        .req_addr_i    (req_addr),
        .req_wdata_i   (req_wdata),
        .req_rd_addr_i (req_rd_addr),
        .req_rd_data_i (req_rd_data),
        .stall_o       (stall),
        .bus           (bus_if.master),
        .wb_valid_o    (wb_valid),
        .wb_rd_addr_o  (wb_rd_addr),
        .wb_rd_data_o  (wb_rd_data),
        .fault_o       (fault),
        .fault_cause_o (fault_cause)
    );

    always #5 clk = ~clk;

    task automatic drive_req(input logic v, input logic [1:0] op, input logic [1:0] sz,
                             input logic sg, input logic [31:0] a, input logic [31:0] wd,
                             input logic [4:0] rd, input logic [31:0] rdd);
        req_valid   = v;
        req_mem_op  = op;
        req_size    = sz;
        req_signed  = sg;
        req_addr    = a;
        req_wdata   = wd;
        req_rd_addr = rd;
        req_rd_data = rdd;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_req(1'b0, OP_NONE, 2'd0, 1'b0, 32'h0, 32'h0, 5'd0, 32'h0);
        bus_if.bus_ack   = 1'b0;
        bus_if.bus_rdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (bus_if.bus_req !== 1'b0) begin n_fail++; $display("FAIL reset_bus_req: got %0h exp 0", bus_if.bus_req); end
        n_checks++; if (bus_if.bus_wrstb !== 4'h0) begin n_fail++; $display("FAIL reset_wrstb: got %0h exp 0", bus_if.bus_wrstb); end
        n_checks++; if (bus_if.bus_addr !== 32'h0) begin n_fail++; $display("FAIL reset_bus_addr: got %0h exp 0", bus_if.bus_addr); end
        n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL reset_wb_valid: got %0h exp 0", wb_valid); end
        n_checks++; if (fault !== 1'b0 || fault_cause !== 2'd0) begin n_fail++; $display("FAIL reset_fault: got %0h/%0h exp 0/0", fault, fault_cause); end
        n_checks++; if (wb_rd_data !== 32'h0 || wb_rd_addr !== 5'd0) begin n_fail++; $display("FAIL reset_wb_data: got %0h/%0h exp 0/0", wb_rd_data, wb_rd_addr); end
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %0h exp 0", stall); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Loads with immediate ack: lane select, masking and extension
    task automatic test_load_align();
        logic [31:0] a_t  [6];
        logic [1:0]  sz_t [6];
        logic        sg_t [6];
        logic [31:0] ex_t [6];
        a_t  = '{32'h103, 32'h102, 32'h102, 32'h101, 32'h108, 32'h100};
        sz_t = '{2'd0, 2'd1, 2'd1, 2'd0, 2'd2, 2'd0};
        sg_t = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        ex_t = '{32'hFFFF_FF80, 32'hFFFF_80FF, 32'h0000_80FF, 32'h0000_0012, 32'h80FF_1234, 32'h0000_0034};
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            drive_req(1'b1, OP_LOAD, sz_t[k], sg_t[k], a_t[k], 32'h0, 5'(7 + k), 32'h0);
            #1;
            n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL load%0d_stall_accept: got %0h exp 1", k, stall); end
            @(posedge clk); #1;
            req_valid = 1'b0;
            n_checks++; if (bus_if.bus_req !== 1'b1 || bus_if.bus_we !== 1'b0) begin n_fail++; $display("FAIL load%0d_bus_req_we: got %0h/%0h exp 1/0", k, bus_if.bus_req, bus_if.bus_we); end
            n_checks++; if (bus_if.bus_addr !== (a_t[k] & 32'hFFFF_FFFC)) begin n_fail++; $display("FAIL load%0d_bus_addr: got %0h exp %0h", k, bus_if.bus_addr, a_t[k] & 32'hFFFF_FFFC); end
            n_checks++; if (bus_if.bus_wrstb !== 4'h0) begin n_fail++; $display("FAIL load%0d_wrstb: got %0h exp 0", k, bus_if.bus_wrstb); end
            @(negedge clk);
            bus_if.bus_ack   = 1'b1;
            bus_if.bus_rdata = 32'h80FF_1234;
            #1;
            n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL load%0d_stall_ack: got %0h exp 0", k, stall); end
            @(posedge clk); #1;
            bus_if.bus_ack = 1'b0;
            n_checks++; if (wb_valid !== 1'b1 || fault !== 1'b0) begin n_fail++; $display("FAIL load%0d_wb_valid: got %0h/%0h exp 1/0", k, wb_valid, fault); end
            n_checks++; if (wb_rd_data !== ex_t[k]) begin n_fail++; $display("FAIL load%0d_wb_data: got %0h exp %0h", k, wb_rd_data, ex_t[k]); end
            n_checks++; if (wb_rd_addr !== 5'(7 + k)) begin n_fail++; $display("FAIL load%0d_wb_rd: got %0h exp %0h", k, wb_rd_addr, 5'(7 + k)); end
            n_checks++; if (bus_if.bus_req !== 1'b0) begin n_fail++; $display("FAIL load%0d_bus_req_drop: got %0h exp 0", k, bus_if.bus_req); end
        end
        @(posedge clk); #1;
        n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL load_wb_pulse: got %0h exp 0", wb_valid); end
    endtask

    // SH to 0x202 with three ack wait cycles
    task automatic test_store_wait();
        int stall_cnt;
        stall_cnt = 0;
        @(negedge clk);
        drive_req(1'b1, OP_STORE, 2'd1, 1'b0, 32'h202, 32'h0000_ABCD, 5'd9, 32'h0);
        #1;
        if (stall === 1'b1) stall_cnt++;
        @(posedge clk); #1;
        req_valid = 1'b0;
        n_checks++; if (bus_if.bus_req !== 1'b1 || bus_if.bus_we !== 1'b1) begin n_fail++; $display("FAIL sh_bus_req_we: got %0h/%0h exp 1/1", bus_if.bus_req, bus_if.bus_we); end
        n_checks++; if (bus_if.bus_wrstb !== 4'b1100) begin n_fail++; $display("FAIL sh_wrstb: got %0h exp c", bus_if.bus_wrstb); end
        n_checks++; if (bus_if.bus_wdata !== 32'hABCD_0000) begin n_fail++; $display("FAIL sh_wdata: got %0h exp abcd0000", bus_if.bus_wdata); end
        n_checks++; if (bus_if.bus_addr !== 32'h200) begin n_fail++; $display("FAIL sh_bus_addr: got %0h exp 200", bus_if.bus_addr); end
        for (int w = 0; w < 3; w++) begin
            @(negedge clk); #1;
            if (stall === 1'b1) stall_cnt++;
            @(posedge clk); #1;
            n_checks++; if (bus_if.bus_req !== 1'b1 || bus_if.bus_wdata !== 32'hABCD_0000 || bus_if.bus_wrstb !== 4'b1100) begin n_fail++; $display("FAIL sh_hold%0d: got req %0h wdata %0h wrstb %0h exp 1/abcd0000/c", w, bus_if.bus_req, bus_if.bus_wdata, bus_if.bus_wrstb); end
            n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL sh_wait_wb%0d: got %0h exp 0", w, wb_valid); end
        end
        @(negedge clk);
        bus_if.bus_ack = 1'b1;
        #1;
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL sh_stall_ack: got %0h exp 0", stall); end
        @(posedge clk); #1;
        bus_if.bus_ack = 1'b0;
        n_checks++; if (stall_cnt !== 4) begin n_fail++; $display("FAIL sh_stall_cycles: got %0d exp 4", stall_cnt); end
        n_checks++; if (wb_valid !== 1'b1 || wb_rd_addr !== 5'd0 || wb_rd_data !== 32'h0) begin n_fail++; $display("FAIL sh_wb: got %0h/%0h/%0h exp 1/0/0", wb_valid, wb_rd_addr, wb_rd_data); end

        // SB to 0x201, ack at once
        @(negedge clk);
        drive_req(1'b1, OP_STORE, 2'd0, 1'b0, 32'h201, 32'h0000_00EF, 5'd2, 32'h0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        n_checks++; if (bus_if.bus_wrstb !== 4'b0010 || bus_if.bus_wdata !== 32'h0000_EF00) begin n_fail++; $display("FAIL sb_lanes: got %0h/%0h exp 2/ef00", bus_if.bus_wrstb, bus_if.bus_wdata); end
        @(negedge clk);
        bus_if.bus_ack = 1'b1;
        @(posedge clk); #1;
        bus_if.bus_ack = 1'b0;
        n_checks++; if (wb_valid !== 1'b1 || wb_rd_addr !== 5'd0) begin n_fail++; $display("FAIL sb_wb: got %0h/%0h exp 1/0", wb_valid, wb_rd_addr); end
    endtask

    task automatic test_misalign();
        @(negedge clk);
        drive_req(1'b1, OP_LOAD, 2'd2, 1'b0, 32'h001, 32'h0, 5'd5, 32'h0);
        #1;
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL mis_stall: got %0h exp 0", stall); end
        @(posedge clk); #1;
        req_valid = 1'b0;
        n_checks++; if (bus_if.bus_req !== 1'b0) begin n_fail++; $display("FAIL mis_bus_req: got %0h exp 0", bus_if.bus_req); end
        n_checks++; if (fault !== 1'b1 || fault_cause !== 2'd1 || wb_valid !== 1'b0) begin n_fail++; $display("FAIL mis_fault: got %0h/%0h/%0h exp 1/1/0", fault, fault_cause, wb_valid); end
        @(posedge clk); #1;
        n_checks++; if (fault !== 1'b0 || fault_cause !== 2'd1) begin n_fail++; $display("FAIL mis_fault_pulse: got %0h/%0h exp 0/1", fault, fault_cause); end
        // size 3 cannot fit a 32-bit bus even at an aligned address
        @(negedge clk);
        drive_req(1'b1, OP_STORE, 2'd3, 1'b0, 32'h008, 32'h0, 5'd5, 32'h0);
        #1;
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL size3_stall: got %0h exp 0", stall); end
        @(posedge clk); #1;
        req_valid = 1'b0;
        n_checks++; if (fault !== 1'b1 || bus_if.bus_req !== 1'b0) begin n_fail++; $display("FAIL size3_fault: got %0h/%0h exp 1/0", fault, bus_if.bus_req); end
    endtask

    task automatic test_timeout();
        int req_cycles;
        logic done;
        req_cycles = 0;
        done = 1'b0;
        @(negedge clk);
        drive_req(1'b1, OP_LOAD, 2'd2, 1'b0, 32'h300, 32'h0, 5'd6, 32'h0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int i = 0; i < 10 && !done; i++) begin
            if (bus_if.bus_req === 1'b1) begin
                req_cycles++;
                n_checks++; if (stall !== (req_cycles < 5)) begin n_fail++; $display("FAIL tmo_stall%0d: got %0h exp %0h", req_cycles, stall, req_cycles < 5); end
                @(posedge clk); #1;
            end else begin
                done = 1'b1;
            end
        end
        n_checks++; if (!done) begin n_fail++; $display("FAIL tmo_bound: got bus_req stuck exp release"); end
        n_checks++; if (req_cycles !== 5) begin n_fail++; $display("FAIL tmo_req_cycles: got %0d exp 5", req_cycles); end
        n_checks++; if (fault !== 1'b1 || fault_cause !== 2'd2 || wb_valid !== 1'b0) begin n_fail++; $display("FAIL tmo_fault: got %0h/%0h/%0h exp 1/2/0", fault, fault_cause, wb_valid); end
        @(negedge clk);
        drive_req(1'b1, OP_NONE, 2'd0, 1'b0, 32'h0, 32'h0, 5'd5, 32'h0000_1234);
        #1;
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL tmo_none_stall: got %0h exp 0", stall); end
        @(posedge clk); #1;
        req_valid = 1'b0;
        n_checks++; if (wb_valid !== 1'b1 || wb_rd_addr !== 5'd5 || wb_rd_data !== 32'h1234 || fault !== 1'b0) begin n_fail++; $display("FAIL tmo_none_wb: got %0h/%0h/%0h/%0h exp 1/5/1234/0", wb_valid, wb_rd_addr, wb_rd_data, fault); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        drive_req(1'b1, OP_NONE, 2'd0, 1'b0, 32'h0, 32'h0, 5'd3, 32'hDEAD_0003);
        #1;
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL b2b_stall0: got %0h exp 0", stall); end
        @(posedge clk); #1;
        n_checks++; if (wb_valid !== 1'b1 || wb_rd_addr !== 5'd3 || wb_rd_data !== 32'hDEAD_0003) begin n_fail++; $display("FAIL b2b_wb0: got %0h/%0h/%0h exp 1/3/dead0003", wb_valid, wb_rd_addr, wb_rd_data); end
        @(negedge clk);
        drive_req(1'b1, OP_NONE, 2'd0, 1'b0, 32'h0, 32'h0, 5'd4, 32'hBEEF_0004);
        #1;
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL b2b_stall1: got %0h exp 0", stall); end
        @(posedge clk); #1;
        n_checks++; if (wb_valid !== 1'b1 || wb_rd_addr !== 5'd4 || wb_rd_data !== 32'hBEEF_0004) begin n_fail++; $display("FAIL b2b_wb1: got %0h/%0h/%0h exp 1/4/beef0004", wb_valid, wb_rd_addr, wb_rd_data); end
        req_valid = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: got %0h exp 0", wb_valid); end
    endtask

    task automatic test_reset_mid_access();
        @(negedge clk);
        drive_req(1'b1, OP_LOAD, 2'd2, 1'b0, 32'h400, 32'h0, 5'd8, 32'h0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        n_checks++; if (bus_if.bus_req !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre_req: got %0h exp 1", bus_if.bus_req); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++; if (bus_if.bus_req !== 1'b0 || wb_valid !== 1'b0 || stall !== 1'b0) begin n_fail++; $display("FAIL rstmid_drop: got %0h/%0h/%0h exp 0/0/0", bus_if.bus_req, wb_valid, stall); end
        n_checks++; if (fault_cause !== 2'd0) begin n_fail++; $display("FAIL rstmid_cause: got %0h exp 0", fault_cause); end
        @(negedge clk);
        rst = 1'b0;
        bus_if.bus_ack   = 1'b1;
        bus_if.bus_rdata = 32'h5555_AAAA;
        @(posedge clk); #1;
        bus_if.bus_ack = 1'b0;
        n_checks++; if (wb_valid !== 1'b0 || fault !== 1'b0 || bus_if.bus_req !== 1'b0) begin n_fail++; $display("FAIL rstmid_late_ack: got %0h/%0h/%0h exp 0/0/0", wb_valid, fault, bus_if.bus_req); end
    endtask

    initial begin
        test_reset();
        test_load_align();
        test_store_wait();
        test_misalign();
        test_timeout();
        test_back_to_back();
        test_reset_mid_access();
        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
